// File: rtl/fix_mac_seq.sv
// Fixed-point dot-product-plus-bias sequencer driving a shared external
// pipelined multiplier and adder; one term is issued at a time.
module fix_mac_seq #(
    parameter int WIDTH       = 16,
    parameter int POINT_WIDTH = 8,
    parameter int MUL_LAT     = 3,
    parameter int ADD_LAT     = 1,
    parameter int LEN_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic [WIDTH-1:0]     cfg_bias,
    output logic                 busy,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic [WIDTH-1:0]     add_s,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 sat_flag,
    output logic [2:0]           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; op_ready is high only in WAIT_OP, out_valid only in OUT.

    localparam int CNT_MAX = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam int P_HI    = 2 * WIDTH - 1;
    localparam int P_MSB   = WIDTH + POINT_WIDTH - 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_OP  = 3'd1,
        MUL_WAIT = 3'd2,
        ADD_WAIT = 3'd3,
        OUT      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               sat_q, sat_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;

    // The product fits the output format only if every bit above the kept
    // slice repeats the slice's sign bit.
    logic [P_HI-P_MSB:0] top_bits;
    logic                overflow;
    logic [WIDTH-1:0]    aligned;
    logic                unused_lsbs;

    assign top_bits    = mul_p[P_HI:P_MSB];
    assign overflow    = (top_bits != '0) && (top_bits != '1);
    assign unused_lsbs = ^mul_p[POINT_WIDTH-1:0];

    always_comb begin
        aligned = mul_p[P_MSB:POINT_WIDTH];
        if (overflow) begin
            aligned = mul_p[P_HI] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = cfg_bias;
                    rem_d   = cfg_len;
                    sat_d   = 1'b0;
                    state_d = (cfg_len == '0) ? OUT : WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (op_valid) begin
                    mul_a_d = op_a;
                    mul_b_d = op_b;
                    cnt_d   = CNT_W'(MUL_LAT);
                    state_d = MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                if (cnt_q == '0) begin
                    add_a_d = acc_q;
                    add_b_d = aligned;
                    if (overflow) begin
                        sat_d = 1'b1;
                    end
                    cnt_d   = CNT_W'(ADD_LAT);
                    state_d = ADD_WAIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ADD_WAIT: begin
                if (cnt_q == '0) begin
                    acc_d   = add_s;
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? OUT : WAIT_OP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            add_a_q <= '0;
            add_b_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign op_ready  = (state_q == WAIT_OP);
    assign out_valid = (state_q == OUT);
    assign out_data  = acc_q;
    assign sat_flag  = sat_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fix_mac_seq.sv
// Bench for fix_mac_seq: pipelined multiplier/adder models, a vector table,
// random jobs checked against a reference model, and hand-written corner cases.
module tb_fix_mac_seq;

    localparam int WIDTH       = 16;
    localparam int POINT_WIDTH = 8;
    localparam int MUL_LAT     = 3;
    localparam int ADD_LAT     = 1;
    localparam int LEN_W       = 8;
    localparam int NVEC        = 7;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [LEN_W-1:0]     cfg_len;
    logic [WIDTH-1:0]     cfg_bias;
    logic                 busy;
    logic                 op_valid;
    logic                 op_ready;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic [2*WIDTH-1:0]   mul_p;
    logic [WIDTH-1:0]     add_a;
    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     add_s;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 sat_flag;
    logic [2:0]           dbg_state;

    fix_mac_seq #(
        .WIDTH(WIDTH), .POINT_WIDTH(POINT_WIDTH), .MUL_LAT(MUL_LAT),
        .ADD_LAT(ADD_LAT), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .cfg_bias(cfg_bias), .busy(busy), .op_valid(op_valid),
        .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .mul_a(mul_a),
        .mul_b(mul_b), .mul_p(mul_p), .add_a(add_a), .add_b(add_b),
        .add_s(add_s), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sat_flag(sat_flag), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / external units ----------------
    always #5 clk = ~clk;

    logic signed [2*WIDTH-1:0] mul_pipe [MUL_LAT];
    logic [WIDTH-1:0]          add_reg;

    always @(posedge clk) begin
        mul_pipe[0] <= $signed(mul_a) * $signed(mul_b);
        for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
        add_reg <= add_a + add_b;
    end
    assign mul_p = mul_pipe[MUL_LAT-1];
    assign add_s = add_reg;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [LEN_W-1:0]       len;
        logic [WIDTH-1:0]       bias;
        logic [3:0][WIDTH-1:0]  a;
        logic [3:0][WIDTH-1:0]  b;
        int                     gap;
        int                     hold;
        logic [WIDTH-1:0]       exp_data;
        logic                   exp_sat;
    } vec_t;

    logic [WIDTH:0] exp_q[$];
    vec_t           vecs [NVEC];
    int             checks = 0;
    int             fails  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH:0] model(input vec_t v);
        logic [WIDTH-1:0] acc;
        logic             sat;
        longint           p, q, maxv, minv;
        acc  = v.bias;
        sat  = 1'b0;
        maxv = (longint'(1) << (WIDTH-1)) - 1;
        minv = -(longint'(1) << (WIDTH-1));
        for (int i = 0; i < int'(v.len); i++) begin
            p = longint'($signed(v.a[i])) * longint'($signed(v.b[i]));
            q = p >>> POINT_WIDTH;
            if (q > maxv) begin
                q = maxv; sat = 1'b1;
            end else if (q < minv) begin
                q = minv; sat = 1'b1;
            end
            acc = acc + q[WIDTH-1:0];
        end
        return {sat, acc};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [LEN_W-1:0] len, input logic [WIDTH-1:0] bias);
        start    = 1'b1;
        cfg_len  = len;
        cfg_bias = bias;
        tick();
        start    = 1'b0;
    endtask

    task automatic send_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int gap);
        int n;
        n = 0;
        op_valid = 1'b0;
        while (!op_ready && n < 200) begin
            tick();
            n++;
        end
        check("op_ready_wait", 32'(n < 200), 32'd1);
        repeat (gap) tick();
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic receive(input int hold, input int t0, output int lat);
        int               n;
        logic [WIDTH-1:0] held;
        logic [WIDTH:0]   exp;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check("out_valid_wait", 32'(n < 200), 32'd1);
        lat  = cyc_cnt - t0 + 1;
        held = out_data;
        repeat (hold) begin
            tick();
            check("out_data_stable", 32'(out_data), 32'(held));
            check("out_valid_held", 32'(out_valid), 32'd1);
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(exp[WIDTH-1:0]));
            check("sat_flag", 32'(sat_flag), 32'(exp[WIDTH]));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input logic [WIDTH:0] exp);
        int t0, lat;
        start_job(v.len, v.bias);
        t0 = cyc_cnt;
        exp_q.push_back(exp);
        for (int i = 0; i < int'(v.len); i++) send_op(v.a[i], v.b[i], v.gap);
        receive(v.hold, t0, lat);
        if (v.gap == 0) begin
            check("latency", 32'(lat), 32'(1 + int'(v.len) * (MUL_LAT + ADD_LAT + 3)));
        end
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t v;
        rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_bias = '0;
        op_valid = 1'b0; op_a = '0; op_b = '0; out_ready = 1'b0;

        //           len   bias     a[3..0]                                   b[3..0]                                   gap hold exp      sat
        vecs[0] = '{8'd3, 16'h0080, {16'h0, 16'h0100, 16'h0100, 16'h0100}, {16'h0, 16'h0200, 16'h0200, 16'h0200}, 0, 0, 16'h0680, 1'b0};
        vecs[1] = '{8'd2, 16'h0000, {16'h0, 16'h0, 16'h0001, 16'hFE80},     {16'h0, 16'h0, 16'h0001, 16'h0200},     0, 0, 16'hFD00, 1'b0};
        vecs[2] = '{8'd1, 16'h0000, {16'h0, 16'h0, 16'h0, 16'h7F00},        {16'h0, 16'h0, 16'h0, 16'h7F00},        0, 0, 16'h7FFF, 1'b1};
        vecs[3] = '{8'd1, 16'h0000, {16'h0, 16'h0, 16'h0, 16'h8000},        {16'h0, 16'h0, 16'h0, 16'h7F00},        0, 0, 16'h8000, 1'b1};
        vecs[4] = '{8'd2, 16'h0100, {16'h0, 16'h0, 16'h0080, 16'h0100},     {16'h0, 16'h0, 16'h0400, 16'h0100},     5, 4, 16'h0400, 1'b0};
        vecs[5] = '{8'd2, 16'h7000, {16'h0, 16'h0, 16'h0100, 16'h7F00},     {16'h0, 16'h0, 16'h0100, 16'h7F00},     0, 0, 16'hF0FF, 1'b1};
        vecs[6] = '{8'd0, 16'h1234, {16'h0, 16'h0, 16'h0, 16'h0},           {16'h0, 16'h0, 16'h0, 16'h0},           0, 2, 16'h1234, 1'b0};

        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_ready", 32'(op_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sat_flag", 32'(sat_flag), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_mul_ab", 32'({mul_a, mul_b}), 32'd0);
        check("rst_add_ab", 32'({add_a, add_b}), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], {vecs[i].exp_sat, vecs[i].exp_data});

        // Zero length: result the very next cycle, no operand handshake, and
        // a start pulse during OUT must not launch a job.
        start_job(8'd0, 16'h1234);
        check("zl_out_valid", 32'(out_valid), 32'd1);
        check("zl_out_data", 32'(out_data), 32'h1234);
        check("zl_op_ready", 32'(op_ready), 32'd0);
        start_job(8'd3, 16'h5555);
        for (int i = 0; i < 3; i++) begin
            check("zl_start_ignored_data", 32'(out_data), 32'h1234);
            check("zl_start_ignored_op_ready", 32'(op_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("zl_idle_after_accept", 32'(busy), 32'd0);

        // Reset during MUL_WAIT of the second term.
        start_job(8'd3, 16'h0000);
        send_op(16'h0100, 16'h0100, 0);
        send_op(16'h0100, 16'h0200, 0);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_op_ready", 32'(op_ready), 32'd0);
        rst = 1'b0;
        tick();
        v = '{8'd1, 16'h0000, {16'h0, 16'h0, 16'h0, 16'h0100}, {16'h0, 16'h0, 16'h0, 16'h0100}, 0, 0, 16'h0100, 1'b0};
        run_vec(v, {v.exp_sat, v.exp_data});

        // Random jobs against the reference model.
        for (int r = 0; r < 8; r++) begin
            v.len  = LEN_W'($urandom_range(1, 4));
            v.bias = WIDTH'($urandom_range(0, 16'hFFFF));
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 0) begin
                    v.a[k] = WIDTH'($signed($urandom_range(0, 16'h0FFF)) - 32'sh0800);
                    v.b[k] = WIDTH'($signed($urandom_range(0, 16'h0FFF)) - 32'sh0800);
                end else begin
                    v.a[k] = WIDTH'($urandom_range(0, 16'hFFFF));
                    v.b[k] = WIDTH'($urandom_range(0, 16'hFFFF));
                end
            end
            v.gap  = $urandom_range(0, 3);
            v.hold = $urandom_range(0, 2);
            run_vec(v, model(v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
